hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller for the five-stage RISC-V core (F/D/E/M/W). It keeps its own shadow copy of the destination-register and control fields for the E, M and W stages, fed from the decoder outputs in D. From these it produces forwarding selects for the E-stage ALU operands, stall and flush strobes for the pipeline registers, and a freeze for data-memory wait states. Saturating event counters record stall and flush activity for performance debug.

## Interface
- No parameters; register index width fixed at 5, counters fixed at 16 bits.
- clk  in  1  rising-edge clock
- reset_n  in  1  synchronous active-low reset
- id_valid  in  1  D stage holds a real instruction
- id_rs1, id_rs2  in  5  D-stage source registers
- id_rd  in  5  D-stage destination register
- id_regwrite  in  1  decoder regwrite for D instruction
- id_resultsrc  in  2  decoder resultsrc; 01 = load
- ex_pc_redirect  in  1  E stage resolved a taken branch or a jal
- mem_wait  in  1  data memory not ready; pipeline must freeze
- stall_f, stall_d  out  1  hold PC / IF-ID register
- stall_emw  out  1  hold ID-EX, EX-MEM, MEM-WB registers
- flush_d, flush_e  out  1  clear IF-ID / ID-EX register to a bubble
- fwd_a_e, fwd_b_e  out  2  operand select: 00 register file, 01 W result, 10 M ALU result
- stall_cnt  out  16  load-use stall cycles, saturating
- flush_cnt  out  16  redirect flushes, saturating

## Operation
- Shadow state, all registered:
  - E stage: rs1, rs2, rd, regwrite, is_load.
  - M stage: rd, regwrite.
  - W stage: rd, regwrite.
- Bubble definition: regwrite = 0, is_load = 0, all register fields = 0.
- Load-use hazard, lu:
  - All of: id_valid, E.is_load, E.rd != 0.
  - And E.rd equals id_rs1 or id_rs2.
- Priority order (combinational outputs):
  1. mem_wait = 1:
     - stall_f = stall_d = stall_emw = 1.
     - flush_d = flush_e = 0.
     - Shadow state holds.
     - Counters hold.
  2. ex_pc_redirect = 1:
     - flush_d = flush_e = 1, all stalls 0.
     - lu is ignored because the D instruction is killed.
     - flush_cnt increments.
  3. lu = 1:
     - stall_f = stall_d = 1, flush_e = 1, stall_emw = 0.
     - stall_cnt increments.
  4. Otherwise all strobes are 0.
- Shadow update on each clock edge when mem_wait = 0:
  - E gets a bubble if flush_e = 1, else the id_* fields.
  - E.regwrite = id_regwrite & id_valid.
  - E.is_load = (id_resultsrc == 01) & id_valid.
  - M gets E; W gets M.
- Forwarding for fwd_a_e; fwd_b_e is identical with rs2:
  - 10 if M.regwrite, M.rd != 0 and M.rd == E.rs1.
  - Else 01 if W.regwrite, W.rd != 0 and W.rd == E.rs1.
  - Else 00.
  - M wins over W when both match.
  - Register x0 is never forwarded.
- Counters:
  - Each increments by 1 per qualifying cycle.
  - Each saturates at 16'hFFFF and never wraps.

## Timing
- All control outputs are combinational from the shadow state and current inputs; zero-cycle latency.
- Forward selects change only on clock edges, since they depend on shadow state only.
- Reset:
  - Synchronous: the clock edge with reset_n = 0 clears all shadow fields to bubble and both counters to 0.
  - Reset overrides mem_wait.
  - While reset_n = 0, outputs still follow the priority rules on the current inputs.
  - After reset, with ex_pc_redirect = 0 and mem_wait = 0, all strobes are 0 and fwd_* = 00 because E, M and W are bubbles.
- Load-use stall:
  - Lasts exactly one cycle.
  - Next cycle E is a bubble, so lu deasserts.
  - The load sits in M; it is not forwarded from M because is_load data is not ALU data.
  - The load reaches W one cycle later, giving fwd = 01 to the dependent instruction, which is now in E.
- mem_wait held N cycles:
  - Outputs are frozen for N cycles.
  - A pending redirect or lu takes effect in the first cycle with mem_wait = 0.
- ex_pc_redirect and lu in the same cycle: only the flush occurs; stall_cnt does not increment.

## Test plan
- Reset:
  - Drive reset_n = 0 for 2 cycles with random inputs.
  - After release, with ex_pc_redirect = 0 and mem_wait = 0: all strobes 0, fwd_* = 00, counters 0.
- Load-use:
  - Decode lw x5 (rd = 5, resultsrc = 01), then add x6,x5,x7.
  - The cycle add is in D gives stall_f = stall_d = flush_e = 1 and stall_cnt = 1.
  - Two cycles later, with add in E: fwd_a_e = 01.
- ALU forwarding:
  - addi x3, then add x4,x3,x3, then sub x8,x3,x4.
  - add in E: fwd_a_e = fwd_b_e = 10.
  - sub in E: fwd_a_e = 01, fwd_b_e = 10.
- Redirect beats load-use: lu condition plus ex_pc_redirect = 1 gives flush_d = flush_e = 1, stall_f = 0, flush_cnt + 1, stall_cnt unchanged.
- Memory wait:
  - mem_wait = 1 for 3 cycles during a pending redirect.
  - During wait: stall_emw = 1, flush_* = 0, shadow unchanged.
  - First cycle after wait: flush_d = flush_e = 1.
- x0 and saturation:
  - Writes to rd = 0 never produce fwd != 00 or a stall.
  - Force 65 540 redirects: flush_cnt = 16'hFFFF.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage core: forwarding selects, load-use stall, redirect flush and mem-wait freeze.
// Control outputs are combinational (zero latency); a mem_wait freeze holds all shadow state and counters.
module hazard_ctrl (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic [4:0] id_rd,
  input  logic       id_regwrite,
  input  logic [1:0] id_resultsrc,
  input  logic       ex_pc_redirect,
  input  logic       mem_wait,
  output logic       stall_f,
  output logic       stall_d,
  output logic       stall_emw,
  output logic       flush_d,
  output logic       flush_e,
  output logic [1:0] fwd_a_e,
  output logic [1:0] fwd_b_e,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  localparam logic [1:0]  FWD_RF  = 2'b00;
  localparam logic [1:0]  FWD_W   = 2'b01;
  localparam logic [1:0]  FWD_M   = 2'b10;
  localparam logic [1:0]  RES_LD  = 2'b01;
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  logic [4:0] e_rs1, e_rs2, e_rd;
  logic       e_regwrite, e_is_load;
  logic [4:0] m_rd, w_rd;
  logic       m_regwrite, w_regwrite;
  logic       lu;

  assign lu = id_valid && e_is_load && (e_rd != 5'd0) &&
              ((e_rd == id_rs1) || (e_rd == id_rs2));

  always_comb begin
    stall_f   = 1'b0;
    stall_d   = 1'b0;
    stall_emw = 1'b0;
    flush_d   = 1'b0;
    flush_e   = 1'b0;
    if (mem_wait) begin
      stall_f   = 1'b1;
      stall_d   = 1'b1;
      stall_emw = 1'b1;
    end else if (ex_pc_redirect) begin
      // The D instruction is killed, so a concurrent load-use is moot.
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (lu) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  function automatic logic [1:0] fwd_sel(input logic [4:0] src);
    if (m_regwrite && (m_rd != 5'd0) && (m_rd == src))
      return FWD_M;
    else if (w_regwrite && (w_rd != 5'd0) && (w_rd == src))
      return FWD_W;
    else
      return FWD_RF;
  endfunction

  assign fwd_a_e = fwd_sel(e_rs1);
  assign fwd_b_e = fwd_sel(e_rs2);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      e_rs1      <= 5'd0;
      e_rs2      <= 5'd0;
      e_rd       <= 5'd0;
      e_regwrite <= 1'b0;
      e_is_load  <= 1'b0;
      m_rd       <= 5'd0;
      m_regwrite <= 1'b0;
      w_rd       <= 5'd0;
      w_regwrite <= 1'b0;
      stall_cnt  <= 16'd0;
      flush_cnt  <= 16'd0;
    end else if (!mem_wait) begin
      if (flush_e) begin
        e_rs1      <= 5'd0;
        e_rs2      <= 5'd0;
        e_rd       <= 5'd0;
        e_regwrite <= 1'b0;
        e_is_load  <= 1'b0;
      end else begin
        e_rs1      <= id_rs1;
        e_rs2      <= id_rs2;
        e_rd       <= id_rd;
        e_regwrite <= id_regwrite & id_valid;
        e_is_load  <= (id_resultsrc == RES_LD) & id_valid;
      end
      m_rd       <= e_rd;
      m_regwrite <= e_regwrite;
      w_rd       <= m_rd;
      w_regwrite <= m_regwrite;
      if (ex_pc_redirect && (flush_cnt != CNT_MAX))
        flush_cnt <= flush_cnt + 16'd1;
      if (!ex_pc_redirect && lu && (stall_cnt != CNT_MAX))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl: stimulus pushes expected outputs, a negedge monitor pops and compares.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_regwrite;
  logic [1:0]  id_resultsrc;
  logic        ex_pc_redirect, mem_wait;
  logic        stall_f, stall_d, stall_emw, flush_d, flush_e;
  logic [1:0]  fwd_a_e, fwd_b_e;
  logic [15:0] stall_cnt, flush_cnt;

  hazard_ctrl dut (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_resultsrc(id_resultsrc),
    .ex_pc_redirect(ex_pc_redirect), .mem_wait(mem_wait),
    .stall_f(stall_f), .stall_d(stall_d), .stall_emw(stall_emw),
    .flush_d(flush_d), .flush_e(flush_e),
    .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // strobe order: {stall_f, stall_d, stall_emw, flush_d, flush_e}
  localparam logic [4:0] NO = 5'b00000;
  localparam logic [4:0] WT = 5'b11100;
  localparam logic [4:0] RD = 5'b00011;
  localparam logic [4:0] LU = 5'b11001;

  typedef struct packed {
    logic [31:0] id;
    logic [4:0]  strb;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   vec    = 0;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [4:0] strb;
      e    = exp_q.pop_front();
      strb = {stall_f, stall_d, stall_emw, flush_d, flush_e};
      checks++;
      if (strb !== e.strb || fwd_a_e !== e.fa || fwd_b_e !== e.fb ||
          stall_cnt !== e.sc || flush_cnt !== e.fc) begin
        errors++;
        $display("FAIL vec%0d got strb=%b fa=%b fb=%b sc=%h fc=%h expected strb=%b fa=%b fb=%b sc=%h fc=%h",
                 e.id, strb, fwd_a_e, fwd_b_e, stall_cnt, flush_cnt,
                 e.strb, e.fa, e.fb, e.sc, e.fc);
      end
    end
  end

  task automatic drv(input logic rn, input logic v, input logic [4:0] r1, input logic [4:0] r2,
                     input logic [4:0] rd, input logic rw, input logic [1:0] rs,
                     input logic red, input logic mw);
    @(posedge clk);
    #1;
    reset_n        = rn;
    id_valid       = v;
    id_rs1         = r1;
    id_rs2         = r2;
    id_rd          = rd;
    id_regwrite    = rw;
    id_resultsrc   = rs;
    ex_pc_redirect = red;
    mem_wait       = mw;
  endtask

  task automatic step(input logic rn, input logic v, input logic [4:0] r1, input logic [4:0] r2,
                      input logic [4:0] rd, input logic rw, input logic [1:0] rs,
                      input logic red, input logic mw, input logic [4:0] strb,
                      input logic [1:0] fa, input logic [1:0] fb,
                      input logic [15:0] sc, input logic [15:0] fc);
    exp_t e;
    drv(rn, v, r1, r2, rd, rw, rs, red, mw);
    vec++;
    e.id = vec; e.strb = strb; e.fa = fa; e.fb = fb; e.sc = sc; e.fc = fc;
    exp_q.push_back(e);
  endtask

  task automatic bubble(input logic [4:0] strb, input logic [1:0] fa, input logic [1:0] fb,
                        input logic [15:0] sc, input logic [15:0] fc);
    step(1, 0, 0, 0, 0, 0, 2'b00, 0, 0, strb, fa, fb, sc, fc);
  endtask

  initial begin
    reset_n        = 1'b0;
    id_valid       = 1'($urandom);
    id_rs1         = 5'($urandom);
    id_rs2         = 5'($urandom);
    id_rd          = 5'($urandom);
    id_regwrite    = 1'($urandom);
    id_resultsrc   = 2'($urandom);
    ex_pc_redirect = 1'($urandom);
    mem_wait       = 1'($urandom);
    drv(0, 1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
        1'($urandom), 2'($urandom), 1'($urandom), 1'($urandom));

    // reset state
    bubble(NO, 0, 0, 0, 0);
    // load-use: lw x5 ; add x6,x5,x7 (held in D one extra cycle)
    step(1, 1, 1, 0, 5, 1, 2'b01, 0, 0, NO, 0, 0, 0, 0);
    step(1, 1, 5, 7, 6, 1, 2'b00, 0, 0, LU, 0, 0, 0, 0);
    step(1, 1, 5, 7, 6, 1, 2'b00, 0, 0, NO, 0, 0, 1, 0);
    bubble(NO, 1, 0, 1, 0);
    // ALU forwarding: addi x3 ; add x4,x3,x3 ; sub x8,x3,x4
    step(1, 1, 0, 0, 3, 1, 2'b00, 0, 0, NO, 0, 0, 1, 0);
    step(1, 1, 3, 3, 4, 1, 2'b00, 0, 0, NO, 0, 0, 1, 0);
    step(1, 1, 3, 4, 8, 1, 2'b00, 0, 0, NO, 2, 2, 1, 0);
    bubble(NO, 1, 2, 1, 0);
    // M beats W: addi x9 ; addi x9,x9 ; add x10,x9,x9
    step(1, 1, 0, 0, 9, 1, 2'b00, 0, 0, NO, 0, 0, 1, 0);
    step(1, 1, 9, 0, 9, 1, 2'b00, 0, 0, NO, 0, 0, 1, 0);
    step(1, 1, 9, 9, 10, 1, 2'b00, 0, 0, NO, 2, 0, 1, 0);
    bubble(NO, 2, 2, 1, 0);
    bubble(NO, 0, 0, 1, 0);
    // redirect beats load-use
    step(1, 1, 1, 0, 5, 1, 2'b01, 0, 0, NO, 0, 0, 1, 0);
    step(1, 1, 5, 7, 6, 1, 2'b00, 1, 0, RD, 0, 0, 1, 0);
    bubble(NO, 0, 0, 1, 1);
    // mem_wait over a pending redirect with M->E forward in flight
    step(1, 1, 0, 0, 12, 1, 2'b00, 0, 0, NO, 0, 0, 1, 1);
    step(1, 1, 12, 0, 13, 1, 2'b00, 0, 0, NO, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++)
      step(1, 0, 0, 0, 0, 0, 2'b00, 1, 1, WT, 2, 0, 1, 1);
    step(1, 0, 0, 0, 0, 0, 2'b00, 1, 0, RD, 2, 0, 1, 1);
    bubble(NO, 0, 0, 1, 2);
    // x0 destinations never stall or forward
    step(1, 1, 1, 0, 0, 1, 2'b01, 0, 0, NO, 0, 0, 1, 2);
    step(1, 1, 0, 0, 15, 1, 2'b00, 0, 0, NO, 0, 0, 1, 2);
    step(1, 1, 0, 0, 0, 1, 2'b00, 0, 0, NO, 0, 0, 1, 2);
    step(1, 1, 0, 0, 16, 1, 2'b00, 0, 0, NO, 0, 0, 1, 2);
    bubble(NO, 0, 0, 1, 2);
    // invalid D slot with load fields must not become a load or a writer
    step(1, 0, 1, 0, 5, 1, 2'b01, 0, 0, NO, 0, 0, 1, 2);
    step(1, 1, 5, 7, 6, 1, 2'b00, 0, 0, NO, 0, 0, 1, 2);
    bubble(NO, 0, 0, 1, 2);
    // flush counter saturation
    for (int i = 0; i < 65540; i++) begin
      logic [15:0] efc;
      efc = (2 + i > 65535) ? 16'hFFFF : 16'(2 + i);
      step(1, 0, 0, 0, 0, 0, 2'b00, 1, 0, RD, 0, 0, 1, efc);
    end
    bubble(NO, 0, 0, 1, 16'hFFFF);
    // reset wins over mem_wait; outputs still follow priority during reset
    step(0, 0, 0, 0, 0, 0, 2'b00, 0, 1, WT, 0, 0, 1, 16'hFFFF);
    bubble(NO, 0, 0, 0, 0);

    @(posedge clk);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
